// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module   : seq_mul_pkg
// Brief    : Shared types and constants for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

  localparam int DATA_W = 16;

  // Control-path states; s0 is the controller's power-up wait state.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } ctrl_state_e;

  typedef struct packed {
    logic loadA;
    logic loadB;
    logic decB;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/seq_mul_bcount.sv
// ============================================================================
// Module   : seq_mul_bcount
// Brief    : Loadable down-counter for operand B; decrement blocked at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_bcount
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = data_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o    = (count_q == '0);
  assign last_o    = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});
  // A decrement request at zero is dropped and flagged instead of wrapping.
  assign illegal_o = dec_i & ~load_i & zero_o;

endmodule

`default_nettype wire

// File: rtl/seq_mul_datapath.sv
// ============================================================================
// Module   : seq_mul_datapath
// Brief    : Repeated-addition multiplier datapath: A, down-counting B, P.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               loadA,
  input  logic               loadB,
  input  logic               decB,
  output logic               zero,
  output logic [2*WIDTH-1:0] product,
  output logic               result_valid,
  output logic               protocol_err
);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic w_step;
  logic w_accum;
  logic w_zero;
  logic w_last;
  logic w_b_illegal;

  // A load always wins over a simultaneous decrement.
  assign w_step  = decB & ~loadA & ~loadB;
  assign w_accum = w_step & ~w_zero;

  seq_mul_bcount #(
    .WIDTH (WIDTH)
  ) u_bcount (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (loadB),
    .data_i    (data_in),
    .dec_i     (w_step),
    .zero_o    (w_zero),
    .last_o    (w_last),
    .illegal_o (w_b_illegal)
  );

  always_comb begin
    a_d     = a_q;
    p_d     = p_q;
    valid_d = valid_q;
    err_d   = err_q | (decB & (loadA | loadB)) | w_b_illegal;

    if (loadA) begin
      a_d     = data_in;
      valid_d = 1'b0;
    end
    if (loadB) begin
      p_d     = '0;
      valid_d = (data_in == '0);
    end else if (w_accum) begin
      p_d = p_q + {{WIDTH{1'b0}}, a_q};
      if (w_last) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign zero         = w_zero;
  assign product      = p_q;
  assign result_valid = valid_q;
  assign protocol_err = err_q;

endmodule

`default_nettype wire
